// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the write-back requesters and the register-file write arbiter.
// The slave modport is the arbiter side; the master modport is the requester/test side.
interface regfile_wr_arbiter_if #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   clr_start;
    logic                   busy;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        input  clr_start,
        output req_ready,
        output busy,
        output rf_we,
        output rf_waddr,
        output rf_wdata
    );

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        output clr_start,
        input  req_ready,
        input  busy,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port, with $zero write drop
// and a 32-entry clear sequence that zeroes every register.
module regfile_wr_arbiter #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

    typedef enum logic {StRun, StClear} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                gnt_found;
    logic [PtrW-1:0]     gnt_idx;
    logic [PtrW-1:0]     idx;
    logic [PtrW-1:0]     ptr_inc;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                xfer;

    // Search upward from ptr_q, wrapping, for the first valid requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PtrW'((32'(ptr_q) + k) % NREQ);
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == PtrW'(i)) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_inc = (gnt_idx == PtrW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign xfer    = gnt_found && (state_q == StRun);

    // Grants are suppressed during reset and while the clear sequence owns the port.
    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = reset && xfer && (gnt_idx == PtrW'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StRun: begin
                if (xfer) begin
                    ptr_d = ptr_inc;
                    // Writes to $zero complete the handshake but never reach the file.
                    if (sel_addr != '0) begin
                        we_d    = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = sel_data;
                    end
                end
                if (bus.clr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            ptr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.busy     = (state_q == StClear);
    assign bus.rf_we    = we_q;
    assign bus.rf_waddr = waddr_q;
    assign bus.rf_wdata = wdata_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: stimulus pushes expected writes into a queue and an
// independent monitor pops and compares every cycle the register-file write enable is high.
module tb_regfile_wr_arbiter;
    localparam int unsigned NREQ   = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;

    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic push_clear(input int unsigned last);
        for (int unsigned a = 0; a <= last; a++) push(ADDR_W'(a), '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every enabled write must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, expected none",
                             bus.rf_waddr, bus.rf_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.rf_waddr), 64'(mon_e.addr));
                    check("wr_data", 64'(bus.rf_wdata), 64'(mon_e.data));
                end
            end
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.clr_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", bus.rf_we, 0);
        check("rst_waddr", bus.rf_waddr, 0);
        check("rst_wdata", bus.rf_wdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.req_ready, 0);

        // First write after reset release.
        reset = 1'b1;
        #1;
        bus.req_valid = 2'b01;
        bus.req_addr  = {5'd0, 5'd5};
        bus.req_data  = {32'h0, 32'hDEADBEEF};
        #1;
        check("first_ready", bus.req_ready, 2'b01);
        push(5'd5, 32'hDEADBEEF);
        tick();
        bus.req_valid = '0;
        check("first_we", bus.rf_we, 1);
        check("first_waddr", bus.rf_waddr, 5);
        check("first_wdata", bus.rf_wdata, 32'hDEADBEEF);
        tick();
        check("idle_we", bus.rf_we, 0);
        check("hold_waddr", bus.rf_waddr, 5);
        check("hold_wdata", bus.rf_wdata, 32'hDEADBEEF);

        // Asynchronous reset mid-cycle clears outputs at once.
        #2;
        bus.req_valid = 2'b01;
        reset = 1'b0;
        #1;
        check("arst_we", bus.rf_we, 0);
        check("arst_waddr", bus.rf_waddr, 0);
        check("arst_wdata", bus.rf_wdata, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_ready", bus.req_ready, 0);
        bus.req_valid = '0;
        tick();
        reset = 1'b1;

        // Round-robin between two always-valid requesters.
        bus.req_valid = 2'b11;
        bus.req_addr  = {5'd7, 5'd3};
        bus.req_data  = {32'h77, 32'h33};
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rr_ready", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 2 == 0) push(5'd3, 32'h33);
            else push(5'd7, 32'h77);
            tick();
        end
        bus.req_valid = '0;

        // Grant 0 so ptr=1, then a $zero write from requester 1 must move ptr back to 0.
        bus.req_valid = 2'b01;
        bus.req_addr  = {5'd0, 5'd4};
        bus.req_data  = {32'h0, 32'h44};
        #1;
        check("pre_drop_ready", bus.req_ready, 2'b01);
        push(5'd4, 32'h44);
        tick();
        bus.req_valid = 2'b10;
        bus.req_addr  = {5'd0, 5'd0};
        bus.req_data  = {32'h12345678, 32'h0};
        #1;
        check("drop_ready", bus.req_ready, 2'b10);
        tick();
        check("drop_we", bus.rf_we, 0);
        bus.req_valid = 2'b11;
        bus.req_addr  = {5'd8, 5'd6};
        bus.req_data  = {32'h88, 32'h66};
        #1;
        check("ptr_after_drop", bus.req_ready, 2'b01);
        push(5'd6, 32'h66);
        tick();
        bus.req_valid = '0;

        // Clear with idle requesters; requesters go valid once it runs.
        bus.clr_start = 1'b1;
        #1;
        check("clr_start_ready", bus.req_ready, 0);
        push_clear(31);
        tick();
        bus.clr_start = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_addr  = {5'd7, 5'd3};
        #1;
        for (int k = 0; k < 32; k++) begin
            check("clr_busy", bus.busy, 1);
            check("clr_ready", bus.req_ready, 0);
            tick();
        end
        check("clr_done_busy", bus.busy, 0);
        check("clr_resume_ready", bus.req_ready, 2'b10);
        bus.req_valid = '0;

        // Grant and clear start at the same edge; a second pulse during clear is ignored.
        bus.req_valid = 2'b10;
        bus.req_addr  = {5'd9, 5'd0};
        bus.req_data  = {32'hA5, 32'h0};
        bus.clr_start = 1'b1;
        #1;
        check("sim_ready", bus.req_ready, 2'b10);
        push(5'd9, 32'hA5);
        push_clear(31);
        tick();
        bus.req_valid = '0;
        bus.clr_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            bus.clr_start = (k == 3);
            check("sim_busy", bus.busy, 1);
            tick();
        end
        bus.clr_start = 1'b0;
        check("sim_done_busy", bus.busy, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_restart", bus.busy, 0);
        end

        // Leave ptr at 1 so the post-reset grant shows it was cleared.
        bus.req_valid = 2'b01;
        bus.req_addr  = {5'd0, 5'd12};
        bus.req_data  = {32'h0, 32'hC};
        #1;
        check("pre_mid_ready", bus.req_ready, 2'b01);
        push(5'd12, 32'hC);
        tick();
        bus.req_valid = '0;

        // Reset after the address-10 clear write.
        bus.clr_start = 1'b1;
        push_clear(10);
        tick();
        bus.clr_start = 1'b0;
        repeat (11) tick();
        check("mid_we", bus.rf_we, 1);
        check("mid_waddr", bus.rf_waddr, 10);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_we", bus.rf_we, 0);
        check("midrst_busy", bus.busy, 0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("post_rst_busy", bus.busy, 0);
            tick();
        end
        bus.req_valid = 2'b11;
        bus.req_addr  = {5'd7, 5'd3};
        bus.req_data  = {32'h77, 32'h33};
        #1;
        check("post_rst_ready", bus.req_ready, 2'b01);
        push(5'd3, 32'h33);
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        check("queue_empty", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Sequencer and arbiter for the 32×32 register file's single write port. Shares the port between `NREQ` requesters using round-robin arbitration with a valid/ready handshake. Drops writes to register 0, the MIPS `$zero` register. Also runs a clear sequence that writes zero to all 32 registers. It sits between the datapath write-back sources and the register file's write enable, address and data inputs.

## Interface
- `NREQ`, 2, number of requesters (2..4)
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width

- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low (asserted at 0); clears all state immediately
- `req_valid`  in  NREQ  requester i has a pending write
- `req_addr`  in  NREQ*ADDR_W  destination of requester i, in slice [i*ADDR_W +: ADDR_W]
- `req_data`  in  NREQ*DATA_W  data of requester i, in slice [i*DATA_W +: DATA_W]
- `req_ready`  out  NREQ  combinational grant; a transfer occurs when valid and ready are both 1 at the edge
- `clr_start`  in  1  level-sampled request to start the clear sequence
- `busy`  out  1  registered; 1 while clear sequence is running
- `rf_we`  out  1  registered register-file write enable
- `rf_waddr`  out  ADDR_W  registered write address
- `rf_wdata`  out  DATA_W  registered write data

## Operation
- FSM states:
  - RUN is the reset state.
  - CLEAR is entered from RUN when `clr_start` is 1 at an edge.
  - CLEAR returns to RUN at the edge after the address-31 write is issued.
- RUN arbitration:
  - Round-robin pointer `ptr` (log2 NREQ bits, reset value 0).
  - The grant goes to the first i with `req_valid[i]`=1, searching from `ptr` upward and wrapping.
  - Exactly one `req_ready` bit is high in a cycle with any valid request; none otherwise.
  - On a transfer, `ptr` becomes the granted index + 1 (mod NREQ). With no transfer, `ptr` holds.
  - `req_ready` does not depend on `req_valid` of the granted requester beyond selection. No ready is asserted without valid.
- Write issue: at a transfer edge the output registers load `rf_we`=1 and the granted address and data.
- Address 0:
  - A transfer with `req_addr`=0 is accepted (handshake completes, `ptr` advances).
  - The output loads `rf_we`=0; the write is dropped.
- No transfer: `rf_we` loads 0, and `rf_waddr`/`rf_wdata` hold their previous values.
- CLEAR:
  - 5-bit counter `cnt` is set to 0 on entry.
  - Each CLEAR edge loads `rf_we`=1, `rf_waddr`=`cnt`, `rf_wdata`=0, then increments `cnt`.
  - 32 writes are issued, addresses 0..31 in order. Address 0 is written here; the drop rule applies only to requesters.
  - `req_ready` is all 0 in CLEAR.
  - `clr_start` is ignored in CLEAR.
- `busy` = 1 exactly while state is CLEAR (registered with the state).
- Reset mid-operation: state returns to RUN and `cnt`=0. Any in-progress clear is abandoned, with no further writes.

## Timing
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=0, `ptr`=0, state RUN. `req_ready`=0 while `reset`=0.
- Write latency: a transfer at edge t puts the write on the `rf_*` outputs during cycle t..t+1. The register file captures it at edge t+1.
- Throughput: one write per cycle, both sustained and during clear.
- `clr_start` and `req_valid` both 1 in the same RUN cycle: the request is granted and issued normally, and CLEAR starts at the same edge.
  - That write appears on the outputs during the first CLEAR cycle.
  - The address-0 clear write follows one edge later.
  - Total clear duration is 32 cycles of `busy`=1.
- Last clear write (addr 31) is loaded at the final CLEAR edge. At that edge state becomes RUN and `busy` falls. Grants resume in that cycle.
- Requesters must hold `req_valid`, address and data stable until the transfer edge.

## Test plan
- Reset: drive `reset`=0 asynchronously mid-cycle.
  - All outputs go to 0 immediately.
  - After release with `req_valid`=2'b01, addr 5, data 0xDEADBEEF: `req_ready`=2'b01. The next cycle shows `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF.
- Round-robin: hold `req_valid`=2'b11 for 4 cycles (addrs 3 and 7).
  - Grants are 0,1,0,1.
  - `rf_waddr` sequence is 3,7,3,7, each one cycle after its grant.
- Zero-register drop: requester 1 writes addr 0, data 0x12345678.
  - `req_ready[1]`=1 and `ptr` advances.
  - The following cycle has `rf_we`=0.
- Clear: pulse `clr_start` in RUN while requesters are idle.
  - `busy`=1 for 32 cycles.
  - `rf_we`=1 with `rf_waddr`=0..31 consecutively and `rf_wdata`=0.
  - `req_ready`=0 throughout, even with `req_valid`=2'b11.
- Simultaneous: `clr_start`=1 and `req_valid`=2'b10 (addr 9, data 0xA5) in the same cycle.
  - Addr 9 / 0xA5 is issued first, then clear writes 0..31.
  - A second `clr_start` pulse during CLEAR has no effect.
- Reset mid-clear: assert `reset` after the addr-10 clear write.
  - `rf_we`=0 and `busy`=0 immediately.
  - After release, no further clear writes occur, and normal grants start from `ptr`=0.
